fetch_32: RTL

FETCH_32 -- requirements
Module: fetch_32

---
 rtl/fetch_32.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_32.sv
// -----------------------------------------------------------------------------
// fetch_32 -- instruction fetch stage with a 2-entry prefetch FIFO.
//
// Issues word reads to instruction memory, queues the returned words together
// with their PCs, and presents the FIFO head to decode. A redirect (taken
// branch/jump) flushes the queue and restarts fetch at the new target. Any
// memory read still in flight at the time of a redirect is completed and its
// data thrown away.
//
// Handshakes:
//   imem: the request is held (imem_req_out=1, imem_addr_out stable) until the
//         cycle imem_ack_in=1; the ack may arrive in the first request cycle.
//         imem_data_in is only looked at in the ack cycle.
//   decode: insn_valid_out=1 with stall_in=0 consumes the head this cycle;
//           with stall_in=1 the head is held unchanged.
//
// Ports:
//   clk_in          clock, all state updates on the rising edge
//   reset_in        synchronous active-high reset
//   stall_in        decode cannot accept an instruction this cycle
//   redirect_in     flush and restart fetch at redirect_pc_in
//   redirect_pc_in  new fetch address (bits [1:0] ignored)
//   imem_req_out    instruction memory read request
//   imem_addr_out   instruction memory byte address (word aligned)
//   imem_ack_in     imem_data_in valid for the pending request
//   imem_data_in    instruction word from memory
//   insn_out        instruction at the FIFO head (0 when empty)
//   insn_pc_out     PC of insn_out (PC of last consumed entry when empty)
//   insn_valid_out  insn_out/insn_pc_out hold a real instruction
//   dbg_state       request FSM state (0 IDLE, 1 REQ, 2 DISCARD)
//   dbg_count       FIFO occupancy (0..2)
// -----------------------------------------------------------------------------
module fetch_32 #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_in,
  input  logic        reset_in,
  input  logic        stall_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  output logic        imem_req_out,
  output logic [31:0] imem_addr_out,
  input  logic        imem_ack_in,
  input  logic [31:0] imem_data_in,
  output logic [31:0] insn_out,
  output logic [31:0] insn_pc_out,
  output logic        insn_valid_out,
  output logic [1:0]  dbg_state,
  output logic [1:0]  dbg_count
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    DISCARD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] fetch_pc;

  // FIFO storage: two {insn, pc} slots addressed by 1-bit pointers.
  logic [31:0] fifo_insn [2];
  logic [31:0] fifo_pc   [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;
  logic [31:0] last_pc;

  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // Masking (rather than slicing) keeps every bit of redirect_pc_in in use.
  assign redirect_target = redirect_pc_in & 32'hFFFF_FFFC;

  // Head of the FIFO is presented directly to decode.
  assign insn_valid_out = (count != 2'd0);
  assign insn_out       = insn_valid_out ? fifo_insn[rd_ptr] : 32'h0000_0000;
  assign insn_pc_out    = insn_valid_out ? fifo_pc[rd_ptr]   : last_pc;

  // A pop in a redirect cycle still counts as consumed by decode.
  assign pop  = insn_valid_out && !stall_in;
  // Only a live (non-discarded) request pushes, and a redirect drops the ack.
  assign push = (state == REQ) && imem_ack_in && !redirect_in;

  assign dbg_state = state;
  assign dbg_count = count;

  // ---------------------------------------------------------------------------
  // FIFO: occupancy, pointers, storage and the last consumed PC.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      count        <= 2'd0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      last_pc      <= RESET_PC;
      fifo_insn[0] <= 32'h0000_0000;
      fifo_insn[1] <= 32'h0000_0000;
      fifo_pc[0]   <= RESET_PC;
      fifo_pc[1]   <= RESET_PC;
    end else begin
      if (pop) begin
        last_pc <= fifo_pc[rd_ptr];
      end

      if (redirect_in) begin
        // Flush: everything not consumed this cycle is thrown away.
        count  <= 2'd0;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
      end else begin
        if (push) begin
          fifo_insn[wr_ptr] <= imem_data_in;
          fifo_pc[wr_ptr]   <= fetch_pc;
          wr_ptr            <= ~wr_ptr;
        end
        if (pop) begin
          rd_ptr <= ~rd_ptr;
        end
        case ({push, pop})
          2'b10:   count <= count + 2'd1;
          2'b01:   count <= count - 2'd1;
          default: count <= count;
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Request FSM with registered memory-side outputs.
  //   IDLE    : issue a request for fetch_pc when the FIFO has room.
  //   REQ     : hold the request until ack; push the word and advance.
  //   DISCARD : a redirect overtook the request; finish it and drop the data.
  // fetch_pc always tracks the next address to be fetched, so after a redirect
  // it already holds the target while imem_addr_out still shows the old
  // address being discarded.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state         <= IDLE;
      fetch_pc      <= RESET_PC;
      imem_req_out  <= 1'b0;
      imem_addr_out <= RESET_PC;
    end else begin
      case (state)
        IDLE: begin
          if (redirect_in) begin
            fetch_pc <= redirect_target;
          end else if (count != 2'd2) begin
            // No push can happen while in IDLE, so a slot is guaranteed
            // to still be free when the ack arrives.
            state         <= REQ;
            imem_req_out  <= 1'b1;
            imem_addr_out <= fetch_pc;
          end
        end

        REQ: begin
          if (redirect_in) begin
            fetch_pc <= redirect_target;
            if (imem_ack_in) begin
              state        <= IDLE;
              imem_req_out <= 1'b0;
            end else begin
              // Keep the request up at the old address until memory answers.
              state <= DISCARD;
            end
          end else if (imem_ack_in) begin
            fetch_pc     <= fetch_pc + 32'd4;
            state        <= IDLE;
            imem_req_out <= 1'b0;
          end
        end

        DISCARD: begin
          // A further redirect only retargets; one discard still suffices.
          if (redirect_in) begin
            fetch_pc <= redirect_target;
          end
          if (imem_ack_in) begin
            state        <= IDLE;
            imem_req_out <= 1'b0;
          end
        end

        default: begin
          state        <= IDLE;
          imem_req_out <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Invariants.
  // ---------------------------------------------------------------------------
  a_count_range: assert property (@(posedge clk_in) disable iff (reset_in)
    count != 2'd3);

  a_no_push_when_full: assert property (@(posedge clk_in) disable iff (reset_in)
    !(push && count == 2'd2));

  a_req_held: assert property (@(posedge clk_in) disable iff (reset_in)
    (imem_req_out && !imem_ack_in) |=> (imem_req_out && $stable(imem_addr_out)));

endmodule
